// File: rtl/binning_pkg.sv
// Shared types and constants for the two-stage binning mode scheduler.
package binning_pkg;

  typedef enum logic [1:0] {
    BIN_BYPASS = 2'd0,
    BIN_2X2    = 2'd1,
    BIN_4X4    = 2'd2,
    BIN_RSV    = 2'd3
  } bin_mode_t;

  localparam int ERR_GEOM    = 0;
  localparam int ERR_CFG     = 1;
  localparam int ERR_OVERLAP = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Returns {bypass1, bypass0} for a committed mode.
  function automatic logic [1:0] mode_bypass(input bin_mode_t m);
    return {m != BIN_4X4, m == BIN_BYPASS};
  endfunction

endpackage

// File: rtl/binning_frame_meas.sv
// Input frame geometry measurement: per-line pixel count, line count,
// line-width consistency and binning-divisibility checks.
module binning_frame_meas
  import binning_pkg::*;
#(
  parameter int LINE_SIZE_MAX   = 4096,
  parameter int FRAME_LINES_MAX = 4096
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               de,
  input  logic                               hs,
  input  logic                               vs,
  input  bin_mode_t                          active_mode,
  output logic [$clog2(LINE_SIZE_MAX):0]     frame_w,
  output logic [$clog2(FRAME_LINES_MAX):0]   frame_h,
  output logic                               frame_done,
  output logic                               geom_err
);

  localparam int WW = $clog2(LINE_SIZE_MAX) + 1;
  localparam int HW = $clog2(FRAME_LINES_MAX) + 1;
  localparam logic [WW-1:0] PIX_MAX  = WW'(LINE_SIZE_MAX);
  localparam logic [HW-1:0] LINE_MAX = HW'(FRAME_LINES_MAX);

  logic          vs_q, hs_q;
  logic [WW-1:0] pix_cnt, ref_w, end_w;
  logic [HW-1:0] line_cnt, end_h;
  logic          line_end, frame_end, first_line, width_bad, div_bad;
  logic [1:0]    mask;

  always_comb begin
    // vs_q keeps a line ending on the same cycle as vs falling inside the frame
    line_end   = hs && !hs_q && (vs || vs_q) && (pix_cnt != '0);
    frame_end  = vs_q && !vs;
    first_line = (line_cnt == '0);
    width_bad  = line_end && !first_line && (pix_cnt != ref_w);
    end_w      = (line_end && first_line) ? pix_cnt : ref_w;
    end_h      = (line_end && line_cnt != LINE_MAX) ? line_cnt + 1'b1 : line_cnt;
    case (active_mode)
      BIN_2X2: mask = 2'b01;
      BIN_4X4: mask = 2'b11;
      default: mask = 2'b00;
    endcase
    div_bad  = frame_end && (((end_w[1:0] | end_h[1:0]) & mask) != 2'b00);
    geom_err = width_bad || div_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      ref_w      <= '0;
      frame_w    <= '0;
      frame_h    <= '0;
      frame_done <= 1'b0;
    end else begin
      vs_q       <= vs;
      hs_q       <= hs;
      frame_done <= frame_end;
      if (frame_end) begin
        frame_w  <= end_w;
        frame_h  <= end_h;
        pix_cnt  <= '0;
        line_cnt <= '0;
        ref_w    <= '0;
      end else if (line_end) begin
        if (first_line) ref_w <= pix_cnt;
        if (line_cnt != LINE_MAX) line_cnt <= line_cnt + 1'b1;
        pix_cnt <= '0;
      end else if (vs && de && pix_cnt != PIX_MAX) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/binning_ctrl.sv
// Frame-synchronous mode scheduler for the 2x2 -> 2x2 binning cascade:
// holds software requests and commits them only while the whole chain is idle.
module binning_ctrl
  import binning_pkg::*;
#(
  parameter int LINE_SIZE_MAX   = 4096,
  parameter int FRAME_LINES_MAX = 4096,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         mode_i,
  input  logic                               mode_wr_i,
  input  logic                               de_i,
  input  logic                               hs_i,
  input  logic                               vs_i,
  input  logic                               vs_last_i,
  input  logic                               err_clr_i,
  output logic                               bypass0_o,
  output logic                               bypass1_o,
  output logic [1:0]                         active_mode_o,
  output logic                               pend_o,
  output logic [$clog2(LINE_SIZE_MAX):0]     frame_w_o,
  output logic [$clog2(FRAME_LINES_MAX):0]   frame_h_o,
  output logic                               frame_done_o,
  output logic [FRAME_CNT_WIDTH-1:0]         frame_cnt_o,
  output logic [2:0]                         err_o
);

  state_t    state, state_next;
  bin_mode_t pend_mode, active_mode;
  logic      pend, bypass0, bypass1;
  logic      commit, frame_start, overlap, wr_ok, wr_bad, geom_err;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
  logic [2:0] err, err_next;

  assign wr_ok  = mode_wr_i && (mode_i != BIN_RSV);
  assign wr_bad = mode_wr_i && (mode_i == BIN_RSV);

  always_comb begin
    state_next  = state;
    commit      = 1'b0;
    frame_start = 1'b0;
    overlap     = 1'b0;
    case (state)
      S_IDLE:
        if (vs_i) begin
          state_next  = S_FRAME;
          frame_start = 1'b1;
        end else if (!vs_last_i && pend) begin
          commit = 1'b1;
        end
      S_FRAME:
        if (!vs_i) state_next = S_DRAIN;
      S_DRAIN:
        // a new frame before the last stage drained would mix settings
        if (vs_i) begin
          state_next  = S_FRAME;
          frame_start = 1'b1;
          overlap     = 1'b1;
        end else if (!vs_last_i) begin
          state_next = S_IDLE;
        end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    err_next = err_clr_i ? 3'b000 : err;
    if (geom_err) err_next[ERR_GEOM]    = 1'b1;
    if (wr_bad)   err_next[ERR_CFG]     = 1'b1;
    if (overlap)  err_next[ERR_OVERLAP] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pend        <= 1'b0;
      pend_mode   <= BIN_BYPASS;
      active_mode <= BIN_BYPASS;
      bypass0     <= 1'b1;
      bypass1     <= 1'b1;
      frame_cnt   <= '0;
      err         <= '0;
    end else begin
      state <= state_next;
      err   <= err_next;
      // a write coinciding with a commit stays pending; the commit uses the old value
      if (wr_ok) begin
        pend      <= 1'b1;
        pend_mode <= bin_mode_t'(mode_i);
      end else if (commit) begin
        pend <= 1'b0;
      end
      if (commit) begin
        active_mode        <= pend_mode;
        {bypass1, bypass0} <= mode_bypass(pend_mode);
      end
      if (frame_start) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  binning_frame_meas #(
    .LINE_SIZE_MAX  (LINE_SIZE_MAX),
    .FRAME_LINES_MAX(FRAME_LINES_MAX)
  ) u_meas (
    .clk        (clk),
    .rst        (rst),
    .de         (de_i),
    .hs         (hs_i),
    .vs         (vs_i),
    .active_mode(active_mode),
    .frame_w    (frame_w_o),
    .frame_h    (frame_h_o),
    .frame_done (frame_done_o),
    .geom_err   (geom_err)
  );

  assign bypass0_o     = bypass0;
  assign bypass1_o     = bypass1;
  assign active_mode_o = active_mode;
  assign pend_o        = pend;
  assign frame_cnt_o   = frame_cnt;
  assign err_o         = err;

endmodule

// File: tb/tb_binning_ctrl.sv
// Directed + randomized check of binning_ctrl against a frame-level model.
module tb_binning_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode_i;
  logic        mode_wr_i, de_i, hs_i, vs_i, vs_last_i, err_clr_i;
  logic        bypass0_o, bypass1_o, pend_o, frame_done_o;
  logic [1:0]  active_mode_o;
  logic [12:0] frame_w_o, frame_h_o;
  logic [15:0] frame_cnt_o;
  logic [2:0]  err_o;

  binning_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mode_i       (mode_i),
    .mode_wr_i    (mode_wr_i),
    .de_i         (de_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .vs_last_i    (vs_last_i),
    .err_clr_i    (err_clr_i),
    .bypass0_o    (bypass0_o),
    .bypass1_o    (bypass1_o),
    .active_mode_o(active_mode_o),
    .pend_o       (pend_o),
    .frame_w_o    (frame_w_o),
    .frame_h_o    (frame_h_o),
    .frame_done_o (frame_done_o),
    .frame_cnt_o  (frame_cnt_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // frame-level reference model
  int       exp_mode = 0, exp_pend = 0, exp_pend_mode = 0, exp_cnt = 0;
  int       chain_busy = 0;
  logic [2:0] exp_err = 3'b000;
  int       bp0_tab [3] = '{1, 0, 0};
  int       bp1_tab [3] = '{1, 1, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_mode(input string tag);
    chk({tag, ".mode"}, active_mode_o, exp_mode);
    chk({tag, ".bp0"}, bypass0_o, bp0_tab[exp_mode]);
    chk({tag, ".bp1"}, bypass1_o, bp1_tab[exp_mode]);
    chk({tag, ".pend"}, pend_o, exp_pend);
  endtask

  task automatic model_write(input int m);
    if (m == 3) exp_err[1] = 1'b1;
    else begin
      exp_pend = 1;
      exp_pend_mode = m;
    end
  endtask

  task automatic write_mode(input int m);
    mode_i = 2'(m);
    mode_wr_i = 1'b1;
    tick();
    mode_wr_i = 1'b0;
    model_write(m);
  endtask

  // release the chain; any pending request is committed while idle
  task automatic settle(input string tag);
    vs_last_i = 1'b0;
    chain_busy = 0;
    repeat (4) tick();
    if (exp_pend != 0) begin
      exp_mode = exp_pend_mode;
      exp_pend = 0;
    end
    check_mode(tag);
  endtask

  task automatic check_err(input string tag);
    repeat (2) tick();
    chk({tag, ".err"}, err_o, exp_err);
  endtask

  task automatic clear_err(input string tag);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    exp_err = 3'b000;
    chk({tag, ".clr"}, err_o, exp_err);
  endtask

  // One input frame: line bad_line (if >=1) carries bad_w pixels; a mode write
  // of wr_val is issued at the start of line wr_line (if >=0).
  task automatic send_frame(input string tag, input int w, input int h, input int bad_line,
                            input int bad_w, input int wr_line, input int wr_val, input int gap);
    int div, n;
    logic bad;
    exp_cnt++;
    if (chain_busy != 0) exp_err[2] = 1'b1;
    div = 1 << exp_mode;
    bad = (bad_line >= 1 && bad_line < h && bad_w != w) ||
          (exp_mode != 0 && ((w % div) != 0 || (h % div) != 0));
    vs_i = 1'b1;
    tick();
    tick();
    for (int l = 0; l < h; l++) begin
      if (l == wr_line) begin
        mode_i = 2'(wr_val);
        mode_wr_i = 1'b1;
        model_write(wr_val);
      end
      n = (l == bad_line) ? bad_w : w;
      hs_i = 1'b0;
      de_i = 1'b1;
      for (int p = 0; p < n; p++) begin
        tick();
        mode_wr_i = 1'b0;
      end
      de_i = 1'b0;
      hs_i = 1'b1;
      if (l == h - 1) vs_i = 1'b0;
      else repeat (gap) tick();
    end
    tick();
    chk({tag, ".done"}, frame_done_o, 1);
    chk({tag, ".w"}, frame_w_o, w);
    chk({tag, ".h"}, frame_h_o, h);
    chk({tag, ".cnt"}, frame_cnt_o, exp_cnt & 16'hFFFF);
    chk({tag, ".mode_held"}, active_mode_o, exp_mode);
    tick();
    chk({tag, ".done_low"}, frame_done_o, 0);
    if (bad) exp_err[0] = 1'b1;
    if (vs_last_i) chain_busy = 1;
    $display("[TB] frame %s %0dx%0d mode=%0d w=%0d h=%0d cnt=%0d", tag, w, h, exp_mode,
             frame_w_o, frame_h_o, frame_cnt_o);
  endtask

  initial begin
    int m, w, h, bl, bw, gp;
    rst = 1'b1;
    mode_i = 2'd0; mode_wr_i = 1'b0; de_i = 1'b0; hs_i = 1'b1;
    vs_i = 1'b0; vs_last_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_mode("reset");
    chk("reset.err", err_o, 0);
    chk("reset.cnt", frame_cnt_o, 0);
    chk("reset.w", frame_w_o, 0);
    chk("reset.done", frame_done_o, 0);
    $display("[TB] reset mode=%0d bp=%0d%0d err=%0d", active_mode_o, bypass1_o, bypass0_o, err_o);

    // write 4x4 while idle: pending one clock, effective two clocks after strobe
    mode_i = 2'd2;
    mode_wr_i = 1'b1;
    tick();
    mode_wr_i = 1'b0;
    chk("wr2.pend", pend_o, 1);
    chk("wr2.mode_before", active_mode_o, 0);
    tick();
    exp_mode = 2;
    check_mode("wr2");
    $display("[TB] write mode=2 active=%0d", active_mode_o);

    // two clean 24x24 frames in 4x4
    send_frame("f24a", 24, 24, -1, 0, -1, 0, 35);
    settle("f24a");
    send_frame("f24b", 24, 24, -1, 0, -1, 0, 35);
    settle("f24b");
    chk("two.cnt", frame_cnt_o, 2);
    check_err("two");

    // mode 1 written mid-frame, held off while last stage is still busy
    vs_last_i = 1'b1;
    send_frame("mid", 24, 24, -1, 0, 3, 1, 35);
    repeat (3) tick();
    check_mode("mid.held");
    settle("mid.commit");
    send_frame("f2x2", 24, 24, -1, 0, -1, 0, 35);
    settle("f2x2");
    check_err("f2x2");

    // short line inside a 24-wide frame
    send_frame("short", 24, 24, 5, 23, -1, 0, 35);
    settle("short");
    check_err("short");
    clear_err("short");

    // 22x22 in 4x4 is not divisible by 4
    write_mode(2);
    settle("m4");
    send_frame("f22", 22, 22, -1, 0, -1, 0, 10);
    settle("f22");
    check_err("f22");
    clear_err("f22");

    // reserved mode: cfg error, pending request untouched
    vs_last_i = 1'b1;
    write_mode(1);
    tick();
    chk("rsv.pend_before", pend_o, 1);
    write_mode(3);
    check_err("rsv");
    chk("rsv.pend", pend_o, 1);
    chk("rsv.mode", active_mode_o, exp_mode);
    settle("rsv");
    clear_err("rsv");

    // overlap: new frame while last stage VS still high
    vs_last_i = 1'b1;
    send_frame("ovA", 8, 8, -1, 0, -1, 0, 4);
    send_frame("ovB", 8, 8, -1, 0, -1, 0, 4);
    check_err("ov");
    settle("ov");
    clear_err("ov");

    // randomized frames against the model
    for (int i = 0; i < 8; i++) begin
      m  = int'($urandom_range(0, 2));
      w  = int'($urandom_range(2, 20));
      h  = int'($urandom_range(2, 10));
      bl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, h - 1)) : -1;
      bw = ($urandom_range(0, 1) == 0) ? w + 1 : w - 1;
      gp = int'($urandom_range(2, 6));
      write_mode(m);
      settle("rnd.mode");
      send_frame("rnd", w, h, bl, bw, -1, 0, gp);
      settle("rnd");
      check_err("rnd");
      clear_err("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
